// File: rtl/regfile_pkg.sv
// Shared constants and debug-port state encoding for the scoreboarded register file.
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;

   typedef enum logic [1:0] {
      DBG_IDLE = 2'd0,
      DBG_WAIT = 2'd1,
      DBG_ACK  = 2'd2
   } dbg_state_e;

endpackage

// File: rtl/regfile_dbg_fsm.sv
// Debug req/ack sequencer: reads complete immediately, writes wait until the core
// write ports are idle so core writeback always has priority.
module regfile_dbg_fsm
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic              i_core_wr,
   input  logic [DATA_W-1:0] i_byp_rdata,
   output logic              o_wr_go,
   output logic              o_ack,
   output logic [DATA_W-1:0] o_rdata
);

   dbg_state_e        r_state;
   dbg_state_e        w_next;
   logic              w_capture;
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= DBG_IDLE;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_rdata <= i_byp_rdata;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      o_wr_go   = 1'b0;
      case (r_state)
         DBG_IDLE: begin
            if (i_req) begin
               if (!i_we) begin
                  w_capture = 1'b1;
                  w_next    = DBG_ACK;
               end else if (!i_core_wr) begin
                  o_wr_go = 1'b1;
                  w_next  = DBG_ACK;
               end else begin
                  w_next = DBG_WAIT;
               end
            end
         end
         DBG_WAIT: begin
            if (!i_core_wr) begin
               o_wr_go = 1'b1;
               w_next  = DBG_ACK;
            end
         end
         DBG_ACK: begin
            w_next = DBG_IDLE;
         end
         default: begin
            w_next = DBG_IDLE;
         end
      endcase
   end

   assign o_ack   = (r_state == DBG_ACK);
   assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, per-register busy scoreboard
// and a debug access port; register 0 reads as zero and is never busy.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 1,
   localparam int ADDR_W   = $clog2(NUM_REGS)
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     issue_en,
   input  logic [ADDR_W-1:0]        issue_addr,
   input  logic                     dbg_req,
   input  logic                     dbg_we,
   input  logic [ADDR_W-1:0]        dbg_addr,
   input  logic [DATA_W-1:0]        dbg_wdata,
   output logic                     dbg_ack,
   output logic [DATA_W-1:0]        dbg_rdata
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;

   // Lookup slot NUM_RD serves the debug port; it shares the bypass path of the read ports.
   logic [ADDR_W-1:0] w_lk_addr [NUM_RD+1];
   logic [DATA_W-1:0] w_lk_data [NUM_RD+1];
   logic              w_lk_hit  [NUM_RD+1];

   logic w_core_wr;
   logic w_dbg_wr_go;

   assign w_core_wr = |wr_en;

   always_comb begin
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         w_lk_addr[p] = rd_addr[p*ADDR_W +: ADDR_W];
      end
      w_lk_addr[NUM_RD] = dbg_addr;
   end

   // Ascending port scan lets the highest-index writer win the bypass.
   always_comb begin
      for (int unsigned p = 0; p < NUM_RD + 1; p++) begin
         w_lk_data[p] = r_regs[w_lk_addr[p]];
         w_lk_hit[p]  = 1'b0;
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == w_lk_addr[p])) begin
               w_lk_hit[p]  = 1'b1;
               w_lk_data[p] = wr_data[w*DATA_W +: DATA_W];
            end
         end
         if (w_lk_addr[p] == '0) begin
            w_lk_data[p] = '0;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         rd_data[p*DATA_W +: DATA_W] = w_lk_data[p];
         rd_busy[p]                  = r_busy[w_lk_addr[p]] & ~w_lk_hit[p];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_regs <= '{default: '0};
         r_busy <= '0;
      end else begin
         // Debug writes only fire while no core port is writing, so they never collide.
         if (w_dbg_wr_go && (dbg_addr != '0)) begin
            r_regs[dbg_addr] <= dbg_wdata;
         end
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != '0)) begin
               r_regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
            end
         end
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
               r_busy[wr_addr[w*ADDR_W +: ADDR_W]] <= 1'b0;
            end
         end
         if (issue_en && (issue_addr != '0)) begin
            r_busy[issue_addr] <= 1'b1;
         end
      end
   end

   regfile_dbg_fsm #(
      .DATA_W (DATA_W)
   ) u_dbg (
      .clk         (clk),
      .rst         (rst),
      .i_req       (dbg_req),
      .i_we        (dbg_we),
      .i_core_wr   (w_core_wr),
      .i_byp_rdata (w_lk_data[NUM_RD]),
      .o_wr_go     (w_dbg_wr_go),
      .o_ack       (dbg_ack),
      .o_rdata     (dbg_rdata)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor compares them.
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int DW  = 32;
   localparam int NR  = 32;
   localparam int NRD = 2;
   localparam int NWR = 2;
   localparam int AW  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic [NWR-1:0]    wr_en;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic              issue_en;
   logic [AW-1:0]     issue_addr;
   logic              dbg_req;
   logic              dbg_we;
   logic [AW-1:0]     dbg_addr;
   logic [DW-1:0]     dbg_wdata;
   logic              dbg_ack;
   logic [DW-1:0]     dbg_rdata;

   regfile_sb #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NUM_RD   (NRD),
      .NUM_WR   (NWR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_ack    (dbg_ack),
      .dbg_rdata  (dbg_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {K_RD, K_BUSY, K_ACK, K_STATE, K_DRD} kind_e;
   typedef struct {
      int          cyc;
      kind_e       kind;
      int          port;
      logic [31:0] exp;
      string       name;
   } chk_t;
   typedef struct {
      logic        chk;
      logic [31:0] exp;
      string       name;
   } dbg_t;

   chk_t chk_q[$];
   dbg_t dbg_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic expect_v(input kind_e k, input int port, input logic [31:0] v, input string nm);
      chk_t e;
      e.cyc  = cyc;
      e.kind = k;
      e.port = port;
      e.exp  = v;
      e.name = nm;
      chk_q.push_back(e);
   endtask

   task automatic expect_dbg(input logic c, input logic [31:0] v, input string nm);
      dbg_t d;
      d.chk  = c;
      d.exp  = v;
      d.name = nm;
      dbg_q.push_back(d);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en[p]            = 1'b1;
      wr_addr[p*AW +: AW] = a;
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   task automatic dbg(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      dbg_req   = 1'b1;
      dbg_we    = we;
      dbg_addr  = a;
      dbg_wdata = d;
   endtask

   // Monitor: drains per-cycle expectations and matches every ack against the debug queue.
   always @(negedge clk) begin
      chk_t        e;
      dbg_t        d;
      logic [31:0] act;
      while (chk_q.size() != 0 && chk_q[0].cyc <= cyc) begin
         e = chk_q.pop_front();
         case (e.kind)
            K_RD:    act = rd_data[e.port*DW +: DW];
            K_BUSY:  act = {31'b0, rd_busy[e.port]};
            K_ACK:   act = {31'b0, dbg_ack};
            K_DRD:   act = dbg_rdata;
            default: act = {30'b0, dut.u_dbg.r_state};
         endcase
         check(e.name, act, e.exp);
      end
      if (dbg_ack) begin
         if (dbg_q.size() == 0) begin
            check("spurious_ack", {31'b0, dbg_ack}, 32'd0);
         end else begin
            d = dbg_q.pop_front();
            if (d.chk) check(d.name, dbg_rdata, d.exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      tick(); tick();
      rst = 1'b1;

      // reset clears storage and busy bits
      wr(0, 5, 32'hDEADBEEF); rd(0, 5);
      expect_v(K_RD, 0, 32'hDEADBEEF, "pre_rst_byp_r5");
      tick(); wr_en = '0; issue_en = 1'b1; issue_addr = 5;
      expect_v(K_RD, 0, 32'hDEADBEEF, "pre_rst_store_r5");
      tick(); issue_en = 1'b0; rd(1, 5);
      expect_v(K_BUSY, 1, 1, "pre_rst_busy_r5");
      rst = 1'b0;
      tick(); rst = 1'b1;
      expect_v(K_RD,   0, 0, "rst_rd0");
      expect_v(K_RD,   1, 0, "rst_rd1");
      expect_v(K_BUSY, 0, 0, "rst_busy0");
      expect_v(K_BUSY, 1, 0, "rst_busy1");
      expect_v(K_ACK,  0, 0, "rst_ack");

      // write with same-cycle bypass; r0 stays zero
      tick(); wr(0, 3, 32'h12345678); rd(0, 3);
      expect_v(K_RD, 0, 32'h12345678, "byp_r3");
      tick(); wr_en = '0;
      expect_v(K_RD, 0, 32'h12345678, "store_r3");
      tick(); wr(0, 0, 32'hFFFFFFFF); rd(0, 0);
      expect_v(K_RD, 0, 0, "byp_r0");
      tick(); wr_en = '0;
      expect_v(K_RD, 0, 0, "store_r0");

      // both ports hit r7: port 1 wins
      tick(); wr(0, 7, 32'h1); wr(1, 7, 32'h2); rd(0, 7); rd(1, 7);
      expect_v(K_RD, 0, 32'h2, "dual_byp_rd0");
      expect_v(K_RD, 1, 32'h2, "dual_byp_rd1");
      tick(); wr_en = '0;
      expect_v(K_RD, 0, 32'h2, "dual_store_r7");

      // scoreboard
      tick(); issue_en = 1'b1; issue_addr = 4; rd(0, 4);
      expect_v(K_BUSY, 0, 0, "busy_r4_before_edge");
      tick(); issue_en = 1'b0;
      expect_v(K_BUSY, 0, 1, "busy_r4_set");
      tick(); wr(0, 4, 32'h44); issue_en = 1'b1; issue_addr = 4;
      expect_v(K_BUSY, 0, 0, "busy_r4_masked_by_wb");
      expect_v(K_RD,   0, 32'h44, "byp_r4_44");
      tick(); wr_en = '0; issue_en = 1'b0;
      expect_v(K_BUSY, 0, 1, "busy_r4_issue_wins");
      tick(); wr(0, 4, 32'h55);
      expect_v(K_BUSY, 0, 0, "busy_r4_wb_same_cycle");
      tick(); wr_en = '0;
      expect_v(K_BUSY, 0, 0, "busy_r4_cleared");
      expect_v(K_RD,   0, 32'h55, "store_r4_55");
      tick(); issue_en = 1'b1; issue_addr = 6; rd(1, 6);
      tick(); issue_en = 1'b0;
      expect_v(K_BUSY, 1, 1, "busy_r6_set");
      tick(); wr(1, 6, 32'h66);
      tick(); wr_en = '0;
      expect_v(K_BUSY, 1, 0, "busy_r6_cleared_port1");

      // debug write held off by core writes for three cycles
      tick(); dbg(1'b1, 9, 32'hA5A5A5A5); wr(0, 2, 32'h22); rd(0, 9);
      expect_v(K_ACK, 0, 0, "dbgw_wait0");
      tick();
      expect_v(K_ACK,   0, 0, "dbgw_wait1");
      expect_v(K_STATE, 0, {30'b0, DBG_WAIT}, "dbgw_state_wait");
      tick();
      expect_v(K_ACK, 0, 0, "dbgw_wait2");
      expect_v(K_RD,  0, 0, "dbgw_r9_not_written");
      tick(); wr_en = '0;
      expect_v(K_ACK,   0, 0, "dbgw_release");
      expect_v(K_STATE, 0, {30'b0, DBG_WAIT}, "dbgw_state_still_wait");
      tick();
      expect_v(K_ACK, 0, 1, "dbgw_ack");
      expect_v(K_RD,  0, 32'hA5A5A5A5, "dbgw_r9_landed");
      expect_dbg(1'b1, 32'h0, "dbgw_rdata_held");
      dbg_req = 1'b0;
      tick();
      expect_v(K_ACK, 0, 0, "dbgw_ack_once");

      // debug reads: plain and bypassed
      tick(); dbg(1'b0, 9, 32'h0);
      expect_v(K_ACK, 0, 0, "dbgr_req_cycle");
      tick(); dbg_req = 1'b0;
      expect_v(K_ACK, 0, 1, "dbgr_ack");
      expect_dbg(1'b1, 32'hA5A5A5A5, "dbgr_r9");
      tick();
      expect_v(K_ACK, 0, 0, "dbgr_ack_once");
      tick(); dbg(1'b0, 3, 32'h0); wr(1, 3, 32'h33); rd(1, 3);
      tick(); dbg_req = 1'b0; wr_en = '0;
      expect_v(K_ACK, 0, 1, "dbgr_byp_ack");
      expect_v(K_RD,  1, 32'h33, "store_r3_33");
      expect_dbg(1'b1, 32'h33, "dbgr_byp_r3");

      // debug write to r0 is acked and discarded
      tick(); dbg(1'b1, 0, 32'hFFFFFFFF); rd(0, 0);
      tick(); dbg_req = 1'b0;
      expect_v(K_ACK, 0, 1, "dbgw_r0_ack");
      expect_v(K_RD,  0, 0, "dbgw_r0_discarded");
      expect_dbg(1'b1, 32'h33, "dbgw_r0_rdata_held");

      // reset while a debug write waits
      tick(); wr(0, 2, 32'h22); dbg(1'b1, 9, 32'h11111111);
      tick(); rst = 1'b0;
      expect_v(K_STATE, 0, {30'b0, DBG_WAIT}, "rst_mid_state_wait");
      tick(); rst = 1'b1; dbg_req = 1'b0; wr_en = '0; rd(0, 9);
      expect_v(K_ACK,   0, 0, "rst_mid_noack");
      expect_v(K_STATE, 0, {30'b0, DBG_IDLE}, "rst_mid_state_idle");
      expect_v(K_RD,    0, 0, "rst_mid_r9");
      expect_v(K_DRD,   0, 0, "rst_mid_dbg_rdata");
      tick();
      expect_v(K_ACK, 0, 0, "rst_mid_noack_later");
      tick(); dbg(1'b0, 9, 32'h0);
      tick(); dbg_req = 1'b0;
      expect_v(K_ACK, 0, 1, "dbgr_after_rst_ack");
      expect_dbg(1'b1, 32'h0, "dbgr_after_rst_r9");

      tick(); tick(); tick();
      @(negedge clk);
      #1;
      while (dbg_q.size() != 0) begin
         dbg_t d;
         d = dbg_q.pop_front();
         n_cmp++;
         n_fail++;
         $display("FAIL %s: dbg_ack never arrived, expected ack with rdata 0x%08h", d.name, d.exp);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core register file: NUM_RD read ports and NUM_WR write ports.
- Writes are on the posedge with same-cycle write-to-read bypass; register 0 is hardwired to zero.
- Adds a per-register scoreboard (busy bits) for pipeline hazard detection, plus a req/ack debug access port for the on-board debug/UART loader.
- Sits between decode (read, issue), writeback (write) and the debug unit.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, >=2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports; 1..4.
- ADDR_W, $clog2(NUM_REGS), derived localparam; not overridable.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at slice i.
- rd_data  out  NUM_RD*DATA_W  combinational read data, bypassed.
- rd_busy  out  NUM_RD  combinational: source register still has a pending producer.
- wr_en  in  NUM_WR  write enable per port.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- issue_en  in  1  marks issue_addr busy (new producer issued).
- issue_addr  in  ADDR_W  destination of the issued instruction.
- dbg_req  in  1  debug request, level; held until dbg_ack.
- dbg_we  in  1  1 = debug write, 0 = debug read; stable while dbg_req is high.
- dbg_addr  in  ADDR_W  debug register address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  debug read result; valid in the dbg_ack cycle and held until the next ack.

Behaviour:
- Reset (rst==0 at posedge): all registers 0, all busy bits 0, FSM to IDLE, dbg_ack=0, dbg_rdata=0. Reset overrides every concurrent write, issue or debug operation, including a debug access in flight, which is dropped with no ack.
- Register 0:
  - Writes to it are discarded.
  - Reads return 0.
  - issue_en to it is ignored, so it is never busy.
- Writes: for each port with wr_en=1 and nonzero address, regs[wr_addr] <= wr_data at the posedge. If several ports hit the same address, the highest-index port wins.
- Read bypass: rd_data[i] is the wr_data of the highest-index port currently writing rd_addr[i]; otherwise it is regs[rd_addr[i]]. Zero-latency, combinational.
- Scoreboard update at each posedge, in priority order:
  - Any wr_en to address a clears busy[a].
  - issue_en to address a sets busy[a]; issue wins over a same-cycle clear on the same address (a new producer supersedes the old one).
- rd_busy[i] = busy[rd_addr[i]] & ~(a same-cycle write to rd_addr[i]). The value is bypassed, so no stall is needed.
- Debug FSM states: IDLE, WAIT, ACK.
  - IDLE, dbg_req=0: stay.
  - IDLE, dbg_req=1, read: capture the bypassed value of dbg_addr into dbg_rdata, go to ACK.
  - IDLE, dbg_req=1, write, no wr_en active: perform the write, go to ACK.
  - IDLE, dbg_req=1, write, any wr_en active: go to WAIT.
  - WAIT: retry each cycle under the same rule; go to ACK once no wr_en is active. There is no timeout; core writes always have priority.
  - ACK: dbg_ack=1 for exactly one cycle, then IDLE. dbg_req is ignored in ACK; the master drops it after seeing the ack.
- Debug writes:
  - Do not change busy bits.
  - Writes to register 0 are acked but discarded.
- Debug reads do not conflict with core writes; they are never delayed.

Decomposition:
- Shared package (regfile_pkg): default DATA_W/NUM_REGS constants and the debug FSM state enum.
- One natural sub-module: regfile_dbg_fsm, which owns the IDLE/WAIT/ACK machine and dbg_ack/dbg_rdata. It receives a "core write active" flag and the bypassed read value from the parent.
- Storage, bypass mux and scoreboard stay in regfile_sb.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then hold rst=0 one cycle -> every rd_data = 0, every rd_busy = 0, dbg_ack = 0.
- Write/bypass: wr_en, wr_addr=3, wr_data=0x12345678, rd_addr[0]=3 in the same cycle -> rd_data[0]=0x12345678 combinationally; next cycle still 0x12345678 from storage. A write to r0 followed by a read of r0 -> 0.
- Dual-write conflict (NUM_WR=2): both ports write r7, port0=0x1 and port1=0x2 -> r7 = 0x2; same-cycle bypass also shows 0x2.
- Scoreboard: issue r4 -> rd_busy=1 on r4 from the next cycle. Writeback to r4 together with issue r4 in the same cycle -> busy stays 1. Writeback r4 alone -> rd_busy=0 in that same cycle, and busy=0 after the edge.
- Debug write blocked: dbg_req write r9=0xA5A5A5A5 while wr_en=1 for 3 cycles -> FSM stays in WAIT and there is no ack. wr_en drops -> write lands, and dbg_ack pulses exactly one cycle later; a subsequent read of r9 = 0xA5A5A5A5.
- Debug read and mid-op reset: a debug read of r9 acks in 2 cycles with dbg_rdata=0xA5A5A5A5. A new debug write during WAIT, with rst=0 -> no ack, FSM in IDLE, r9=0.
